// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared phase encoding and lamp-encoding constants for the
//                intersection controllers (multi-direction, single-light and
//                pedestrian blocks).
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

   // Controller phases
   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2,
      ST_FLASH   = 2'd3
   } state_t;

   // Per-direction lamp word, ordered {green, yellow, red}
   typedef logic [2:0] lamp_t;

   localparam lamp_t c_lamp_off    = 3'b000;
   localparam lamp_t c_lamp_red    = 3'b001;
   localparam lamp_t c_lamp_yellow = 3'b010;
   localparam lamp_t c_lamp_green  = 3'b100;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/rr_next_dir.sv
`default_nettype none
// ============================================================================
//  Module      : rr_next_dir
//  Description : Combinational round-robin search for the next direction to
//                receive green. Scans demand starting at active_dir+1 and
//                wrapping (active_dir itself is examined last); falls back to
//                active_dir+1 when nothing is pending or skipping is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_next_dir #(
   parameter int  NUM_DIRS   = 2,
   parameter int  SKIP_EMPTY = 1,
   localparam int c_dir_w    = $clog2(NUM_DIRS)
) (
   input  logic [c_dir_w-1:0]  i_active_dir,
   input  logic [NUM_DIRS-1:0] i_demand,
   output logic [c_dir_w-1:0]  o_next_dir
);

   logic [c_dir_w-1:0] w_fallback;

   // Plain rotation: active_dir+1 modulo NUM_DIRS (NUM_DIRS need not be 2^n)
   assign w_fallback = (i_active_dir == c_dir_w'(NUM_DIRS - 1)) ? '0
                                                              : i_active_dir + c_dir_w'(1);

   generate
      if (SKIP_EMPTY != 0) begin : g_skip
         logic [c_dir_w:0]   w_idx;
         logic [c_dir_w-1:0] w_pick;

         // Scan farthest-to-nearest so the nearest pending direction wins last
         always_comb begin
            w_pick = w_fallback;
            w_idx  = '0;
            for (int k = NUM_DIRS; k >= 1; k--) begin
               w_idx = {1'b0, i_active_dir} + (c_dir_w + 1)'(k);
               if (w_idx >= (c_dir_w + 1)'(NUM_DIRS)) begin
                  w_idx = w_idx - (c_dir_w + 1)'(NUM_DIRS);
               end
               if (i_demand[w_idx[c_dir_w-1:0]]) begin
                  w_pick = w_idx[c_dir_w-1:0];
               end
            end
         end

         assign o_next_dir = w_pick;
      end else begin : g_fixed
         logic w_unused_demand;
         assign w_unused_demand = ^i_demand;
         assign o_next_dir      = w_fallback;
      end
   endgenerate

endmodule : rr_next_dir
`default_nettype wire

// File: rtl/traffic_controller.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_controller
//  Description : Multi-direction intersection controller. Sequences NUM_DIRS
//                directions through green, yellow and all-red phases with
//                its own tick-driven countdown, sticky per-direction demand,
//                optional round-robin skipping and a flashing-yellow
//                maintenance mode entered only at the end of all-red.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_controller
   import traffic_pkg::*;
#(
   parameter int  NUM_DIRS     = 2,
   parameter int  TIMER_WIDTH  = 7,
   parameter int  GREEN_TIME   = 30,
   parameter int  YELLOW_TIME  = 4,
   parameter int  ALL_RED_TIME = 2,
   parameter int  SKIP_EMPTY   = 1,
   localparam int c_dir_w      = $clog2(NUM_DIRS)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   tick,
   input  logic [NUM_DIRS-1:0]    request,
   input  logic                   flash,
   output logic [NUM_DIRS-1:0]    green_lights,
   output logic [NUM_DIRS-1:0]    yellow_lights,
   output logic [NUM_DIRS-1:0]    red_lights,
   output logic [c_dir_w-1:0]     active_dir,
   output logic [TIMER_WIDTH-1:0] phase_timer
);

   localparam logic [TIMER_WIDTH-1:0] c_green_load   = TIMER_WIDTH'(GREEN_TIME - 1);
   localparam logic [TIMER_WIDTH-1:0] c_yellow_load  = TIMER_WIDTH'(YELLOW_TIME - 1);
   localparam logic [TIMER_WIDTH-1:0] c_all_red_load = TIMER_WIDTH'(ALL_RED_TIME - 1);

   // Reject configurations the countdown cannot represent
   generate
      if (NUM_DIRS < 2 || NUM_DIRS > 8) begin : g_bad_dirs
         $error("traffic_controller: NUM_DIRS must be 2..8");
      end
      if (GREEN_TIME < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1) begin : g_bad_time
         $error("traffic_controller: phase lengths must be >= 1");
      end
      if ((GREEN_TIME - 1) >= (1 << TIMER_WIDTH) ||
          (YELLOW_TIME - 1) >= (1 << TIMER_WIDTH) ||
          (ALL_RED_TIME - 1) >= (1 << TIMER_WIDTH)) begin : g_bad_width
         $error("traffic_controller: a phase length does not fit TIMER_WIDTH");
      end
   endgenerate

   state_t                   r_state,      w_state_nxt;
   logic [TIMER_WIDTH-1:0]   r_timer,      w_timer_nxt;
   logic [c_dir_w-1:0]       r_active_dir, w_dir_nxt;
   logic [NUM_DIRS-1:0]      r_demand,     w_demand_nxt;
   logic                     r_flash_on,   w_flash_on_nxt;
   logic                     w_enter_green;
   logic [c_dir_w-1:0]       w_rr_dir;
   lamp_t                    w_lamp;

   rr_next_dir #(
      .NUM_DIRS   (NUM_DIRS),
      .SKIP_EMPTY (SKIP_EMPTY)
   ) u_rr_next_dir (
      .i_active_dir (r_active_dir),
      .i_demand     (r_demand),
      .o_next_dir   (w_rr_dir)
   );

   // State, countdown, active direction, demand and flash phase registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_ALL_RED;
         r_timer      <= c_all_red_load;
         r_active_dir <= c_dir_w'(NUM_DIRS - 1);
         r_demand     <= '0;
         r_flash_on   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_active_dir <= w_dir_nxt;
         r_demand     <= w_demand_nxt;
         r_flash_on   <= w_flash_on_nxt;
      end
   end

   // Phase sequencing on ticks, plus demand latching (clear beats set)
   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = r_timer;
      w_dir_nxt      = r_active_dir;
      w_flash_on_nxt = r_flash_on;
      w_enter_green  = 1'b0;

      if (tick) begin
         case (r_state)
            ST_GREEN: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TIMER_WIDTH'(1);
               end else begin
                  w_state_nxt = ST_YELLOW;
                  w_timer_nxt = c_yellow_load;
               end
            end
            ST_YELLOW: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TIMER_WIDTH'(1);
               end else begin
                  w_state_nxt = ST_ALL_RED;
                  w_timer_nxt = c_all_red_load;
               end
            end
            ST_ALL_RED: begin
               if (r_timer != '0) begin
                  w_timer_nxt = r_timer - TIMER_WIDTH'(1);
               end else if (flash) begin
                  w_state_nxt    = ST_FLASH;
                  w_timer_nxt    = '0;
                  w_flash_on_nxt = 1'b1;
               end else begin
                  w_state_nxt   = ST_GREEN;
                  w_timer_nxt   = c_green_load;
                  w_dir_nxt     = w_rr_dir;
                  w_enter_green = 1'b1;
               end
            end
            default: begin
               // Flash mode: timer parked at zero, lamps blink once per tick
               if (flash) begin
                  w_flash_on_nxt = ~r_flash_on;
               end else begin
                  w_state_nxt    = ST_ALL_RED;
                  w_timer_nxt    = c_all_red_load;
                  w_flash_on_nxt = 1'b0;
               end
            end
         endcase
      end

      // A direction already holding green does not re-queue itself
      w_demand_nxt = r_demand | request;
      if (r_state == ST_GREEN) begin
         w_demand_nxt[r_active_dir] = 1'b0;
      end
      if (w_enter_green) begin
         w_demand_nxt[w_rr_dir] = 1'b0;
      end
   end

   // Lamp decode purely from registered state
   always_comb begin
      green_lights  = '0;
      yellow_lights = '0;
      red_lights    = '0;
      w_lamp        = c_lamp_red;
      for (int d = 0; d < NUM_DIRS; d++) begin
         w_lamp = c_lamp_red;
         case (r_state)
            ST_GREEN:  if (r_active_dir == c_dir_w'(d)) w_lamp = c_lamp_green;
            ST_YELLOW: if (r_active_dir == c_dir_w'(d)) w_lamp = c_lamp_yellow;
            ST_FLASH:  w_lamp = r_flash_on ? c_lamp_yellow : c_lamp_off;
            default:   w_lamp = c_lamp_red;
         endcase
         {green_lights[d], yellow_lights[d], red_lights[d]} = w_lamp;
      end
   end

   assign active_dir  = r_active_dir;
   assign phase_timer = r_timer;

endmodule : traffic_controller
`default_nettype wire

// File: tb/tb_traffic_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_controller
//  Description : Self-checking bench for traffic_controller. Two instances
//                (fixed rotation and demand skipping) share stimulus and are
//                compared every clock against a phase/elapsed-tick model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_controller;

   localparam int N  = 4;
   localparam int GT = 5;
   localparam int YT = 2;
   localparam int AT = 1;

   localparam int P_RED = 0;
   localparam int P_GRN = 1;
   localparam int P_YEL = 2;
   localparam int P_FL  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       flash;
   logic [3:0] request;

   logic [3:0] g0, y0, r0, g1, y1, r1;
   logic [1:0] ad0, ad1;
   logic [6:0] pt0, pt1;

   always #5 clk = ~clk;

   traffic_controller #(
      .NUM_DIRS(N), .TIMER_WIDTH(7), .GREEN_TIME(GT), .YELLOW_TIME(YT),
      .ALL_RED_TIME(AT), .SKIP_EMPTY(0)
   ) dut0 (
      .clock(clk), .reset_n(rst_n), .tick(tick), .request(request), .flash(flash),
      .green_lights(g0), .yellow_lights(y0), .red_lights(r0),
      .active_dir(ad0), .phase_timer(pt0)
   );

   traffic_controller #(
      .NUM_DIRS(N), .TIMER_WIDTH(7), .GREEN_TIME(GT), .YELLOW_TIME(YT),
      .ALL_RED_TIME(AT), .SKIP_EMPTY(1)
   ) dut1 (
      .clock(clk), .reset_n(rst_n), .tick(tick), .request(request), .flash(flash),
      .green_lights(g1), .yellow_lights(y1), .red_lights(r1),
      .active_dir(ad1), .phase_timer(pt1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phase name, ticks elapsed in phase, direction, demand set
   int         m_ph  [2];
   int         m_el  [2];
   int         m_dir [2];
   int         m_fon [2];
   logic [3:0] m_dem [2];

   typedef struct {
      logic [3:0] req;
      logic       fl;
      logic [3:0] g, y, r;
      logic [1:0] dir;
      logic [6:0] tmr;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int ph_len(input int ph);
      if (ph == P_GRN) return GT;
      if (ph == P_YEL) return YT;
      return AT;
   endfunction

   function automatic int pick_next(input int i);
      int  nd;
      bit  found;
      nd    = (m_dir[i] + 1) % N;
      found = 1'b0;
      if (i == 1) begin
         for (int off = 1; off <= N; off++) begin
            int d;
            d = (m_dir[i] + off) % N;
            if (!found && m_dem[i][d]) begin
               nd    = d;
               found = 1'b1;
            end
         end
      end
      return nd;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i]  = P_RED;
         m_el[i]  = 0;
         m_dir[i] = N - 1;
         m_fon[i] = 0;
         m_dem[i] = 4'h0;
      end
   endtask

   task automatic model_step(input int i);
      logic [3:0] nd;
      nd = m_dem[i] | request;
      if (m_ph[i] == P_GRN) nd[m_dir[i]] = 1'b0;
      if (tick) begin
         if (m_ph[i] == P_FL) begin
            if (flash) m_fon[i] = 1 - m_fon[i];
            else begin
               m_ph[i]  = P_RED;
               m_el[i]  = 0;
               m_fon[i] = 0;
            end
         end else begin
            m_el[i] = m_el[i] + 1;
            if (m_el[i] == ph_len(m_ph[i])) begin
               m_el[i] = 0;
               if (m_ph[i] == P_GRN)      m_ph[i] = P_YEL;
               else if (m_ph[i] == P_YEL) m_ph[i] = P_RED;
               else if (flash) begin
                  m_ph[i]  = P_FL;
                  m_fon[i] = 1;
               end else begin
                  m_dir[i]     = pick_next(i);
                  m_ph[i]      = P_GRN;
                  nd[m_dir[i]] = 1'b0;
               end
            end
         end
      end
      m_dem[i] = nd;
   endtask

   // Packed layout {11'b0, green, yellow, red, active_dir, phase_timer}
   function automatic logic [31:0] model_out(input int i);
      logic [3:0] g, y, r;
      logic [6:0] t;
      g = 4'h0; y = 4'h0; r = 4'h0;
      for (int d = 0; d < N; d++) begin
         if (m_ph[i] == P_FL)                        y[d] = (m_fon[i] != 0);
         else if (m_ph[i] == P_GRN && d == m_dir[i]) g[d] = 1'b1;
         else if (m_ph[i] == P_YEL && d == m_dir[i]) y[d] = 1'b1;
         else                                        r[d] = 1'b1;
      end
      t = (m_ph[i] == P_FL) ? 7'd0 : 7'(ph_len(m_ph[i]) - 1 - m_el[i]);
      return {11'b0, g, y, r, 2'(m_dir[i]), t};
   endfunction

   function automatic bit inv_ok(input logic [3:0] g, input logic [3:0] y, input logic [3:0] r);
      int lit;
      if (g == 4'h0 && r == 4'h0 && (y == 4'h0 || y == 4'hF)) return 1'b1;
      lit = 0;
      for (int d = 0; d < N; d++) begin
         if ({g[d], y[d], r[d]} != 3'b100 && {g[d], y[d], r[d]} != 3'b010 &&
             {g[d], y[d], r[d]} != 3'b001) return 1'b0;
         if (!r[d]) lit++;
      end
      return (lit <= 1);
   endfunction

   task automatic check_all();
      chk("dut0 outputs vs model", {11'b0, g0, y0, r0, ad0, pt0}, model_out(0));
      chk("dut1 outputs vs model", {11'b0, g1, y1, r1, ad1, pt1}, model_out(1));
      chk("dut0 lamp invariant", 32'(inv_ok(g0, y0, r0)), 32'd1);
      chk("dut1 lamp invariant", 32'(inv_ok(g1, y1, r1)), 32'd1);
   endtask

   task automatic clk_cycle();
      @(posedge clk);
      if (rst_n) begin
         model_step(0);
         model_step(1);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick = 1'b1;
         clk_cycle();
         tick = 1'b0;
         repeat (3) clk_cycle();
      end
   endtask

   // Reset asserted between clock edges; lamps must go red before any edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset dut0 lamps", {20'b0, g0, y0, r0}, {20'b0, 4'h0, 4'h0, 4'hF});
      chk("reset dut1 lamps", {20'b0, g1, y1, r1}, {20'b0, 4'h0, 4'h0, 4'hF});
      chk("reset dut0 dir/timer", {23'b0, ad0, pt0}, {23'b0, 2'd3, 7'd0});
      repeat (2) clk_cycle();
      rst_n = 1'b1;
   endtask

   task automatic apply_table(input string tag);
      for (int i = 0; i < 9; i++) begin
         request = tbl[i].req;
         flash   = tbl[i].fl;
         run_ticks(1);
         chk($sformatf("%s tick%0d dut0", tag, i + 1), {11'b0, g0, y0, r0, ad0, pt0},
             {11'b0, tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].dir, tbl[i].tmr});
         chk($sformatf("%s tick%0d dut1", tag, i + 1), {11'b0, g1, y1, r1, ad1, pt1},
             {11'b0, tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].dir, tbl[i].tmr});
      end
      request = 4'h0;
      flash   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] e;

      // Expected lamps after each tick from reset with no demand
      tbl[0] = '{4'h0, 1'b0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 7'd4};
      tbl[1] = '{4'h0, 1'b0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 7'd3};
      tbl[2] = '{4'h0, 1'b0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 7'd2};
      tbl[3] = '{4'h0, 1'b0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 7'd1};
      tbl[4] = '{4'h0, 1'b0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 7'd0};
      tbl[5] = '{4'h0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 2'd0, 7'd1};
      tbl[6] = '{4'h0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 2'd0, 7'd0};
      tbl[7] = '{4'h0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 2'd0, 7'd0};
      tbl[8] = '{4'h0, 1'b0, 4'b0010, 4'b0000, 4'b1101, 2'd1, 7'd4};

      rst_n   = 1'b0;
      tick    = 1'b0;
      flash   = 1'b0;
      request = 4'h0;
      model_reset();
      repeat (2) clk_cycle();
      rst_n = 1'b1;

      // Basic rotation from reset, then wrap dir3 -> dir0
      do_reset();
      apply_table("rotation");
      for (int j = 0; j < 3; j++) begin
         run_ticks(8);
         e = 4'b0001 << ((2 + j) % 4);
         chk($sformatf("wrap step%0d dut0 green", j), {28'b0, g0}, {28'b0, e});
      end

      // Pulsed request[2] during dir0 green: skipping instance jumps to dir2
      do_reset();
      run_ticks(1);
      request = 4'b0100;
      clk_cycle();
      request = 4'h0;
      run_ticks(8);
      chk("skip dut1 green dir2", {26'b0, g1, ad1}, {26'b0, 4'b0100, 2'd2});
      chk("skip dut0 green dir1", {26'b0, g0, ad0}, {26'b0, 4'b0010, 2'd1});
      run_ticks(8);
      chk("skip demand cleared dut1", {26'b0, g1, ad1}, {26'b0, 4'b1000, 2'd3});

      // Flash requested during dir1 green
      do_reset();
      run_ticks(9);
      flash = 1'b1;
      run_ticks(5);
      chk("flash yellow completes", {24'b0, g0, y0}, {24'b0, 4'b0000, 4'b0010});
      run_ticks(2);
      chk("flash all red first", {28'b0, r1}, {28'b0, 4'hF});
      run_ticks(1);
      chk("flash on", {20'b0, g0, y0, r0}, {20'b0, 4'h0, 4'hF, 4'h0});
      run_ticks(1);
      chk("flash off", {20'b0, g1, y1, r1}, {20'b0, 4'h0, 4'h0, 4'h0});
      flash = 1'b0;
      run_ticks(1);
      chk("flash exit all red", {20'b0, g0, y0, r0}, {20'b0, 4'h0, 4'h0, 4'hF});
      run_ticks(1);
      chk("flash exit dir2 green", {26'b0, g0, ad0}, {26'b0, 4'b0100, 2'd2});

      // Asynchronous reset in mid-yellow with demand pending
      do_reset();
      run_ticks(6);
      request = 4'b0100;
      clk_cycle();
      request = 4'h0;
      do_reset();
      apply_table("restart");

      // Current green direction holding its request is not re-queued
      do_reset();
      run_ticks(1);
      request = 4'b0001;
      run_ticks(4);
      tick = 1'b1;
      clk_cycle();
      tick    = 1'b0;
      request = 4'h0;
      repeat (3) clk_cycle();
      run_ticks(3);
      chk("self request ignored dut1", {26'b0, g1, ad1}, {26'b0, 4'b0010, 2'd1});

      // No ticks for 100 clocks mid-green
      do_reset();
      run_ticks(2);
      repeat (100) clk_cycle();
      chk("tick hold dut0", {21'b0, g0, pt0}, {21'b0, 4'b0001, 7'd3});
      chk("tick hold dut1", {21'b0, g1, pt1}, {21'b0, 4'b0001, 7'd3});

      // Randomised traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         tick    = ($urandom_range(0, 3) == 0);
         request = 4'($urandom) & 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 149) == 0) flash = ~flash;
         clk_cycle();
      end
      tick    = 1'b0;
      flash   = 1'b0;
      request = 4'h0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_traffic_controller
`default_nettype wire

// File: doc/traffic_controller.md
Name: traffic_controller

Overview:
Multi-direction intersection controller; successor to the single-light decoder. Owns its own phase countdown instead of relying on an external master timer. Sequences N directions through green, yellow and all-red phases, with sticky per-direction demand and round-robin skipping. Adds a flashing-yellow maintenance mode. Sits between the 1 Hz tick generator and the lamp drivers.

Parameters:
NUM_DIRS, 2, number of controlled directions (2..8)
TIMER_WIDTH, 7, width of phase countdown; elaboration error if any *_TIME-1 does not fit
GREEN_TIME, 30, green phase length in ticks (>=1)
YELLOW_TIME, 4, yellow phase length in ticks (>=1)
ALL_RED_TIME, 2, all-red clearance length in ticks (>=1)
SKIP_EMPTY, 1, 1 = next green goes to the next direction with latched demand; 0 = fixed rotation

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
tick  input  1  one-cycle timing strobe (1 Hz nominal); all phase timing counts ticks only
request  input  NUM_DIRS  per-direction demand (vehicle sensor/ped button), level or pulse
flash  input  1  maintenance mode request
green_lights  output  NUM_DIRS  per-direction green lamp
yellow_lights  output  NUM_DIRS  per-direction yellow lamp
red_lights  output  NUM_DIRS  per-direction red lamp
active_dir  output  $clog2(NUM_DIRS)  direction currently holding green/yellow
phase_timer  output  TIMER_WIDTH  remaining ticks-1 in current phase

Behaviour:
- States: ALL_RED, GREEN, YELLOW, FLASH. Registers: state, phase_timer, active_dir, demand[NUM_DIRS], flash_on.
- Reset (async assert, any time incl. mid-phase): state=ALL_RED, phase_timer=ALL_RED_TIME-1, active_dir=NUM_DIRS-1, demand=0, flash_on=0. Lamps: all red=1, green=0, yellow=0.
- Lamps are pure decode of registered state; no combinational path from inputs to lamps.
  GREEN: active green=1, others red. YELLOW: active yellow=1, others red. ALL_RED: all red. FLASH: all yellow=flash_on, red=0, green=0.
- Per direction, exactly one of green/yellow/red is 1, except FLASH (all 0 or yellow only). At most one direction non-red outside FLASH.
- Countdown: on a cycle with tick=1, if phase_timer!=0 decrement; else take the transition and load the next phase length-1. A phase therefore lasts exactly *_TIME ticks. tick=0: state and timer hold.
- Transitions (on tick with phase_timer==0):
  GREEN -> YELLOW (load YELLOW_TIME-1).
  YELLOW -> ALL_RED (load ALL_RED_TIME-1).
  ALL_RED -> FLASH if flash=1 (flash_on=1); else GREEN (load GREEN_TIME-1) with active_dir=next.
  FLASH: every tick toggles flash_on; timer held at 0. On tick with flash=0 -> ALL_RED (load ALL_RED_TIME-1), flash_on=0.
- flash only takes effect at the end of ALL_RED; an active green/yellow always completes.
- Next direction: SKIP_EMPTY=1 -> first d with demand[d]=1 searching active_dir+1, +2, ... mod NUM_DIRS (active_dir itself last). If no demand, active_dir+1 mod NUM_DIRS. SKIP_EMPTY=0 -> always active_dir+1 mod NUM_DIRS.
- Demand: demand[d] sets on request[d]=1 on any clock. Cleared when d enters GREEN. request[d] for the direction currently GREEN is not latched. Set and clear in the same cycle: clear wins.
- Demand is latched in every state, including FLASH.

Decomposition:
- Shared package traffic_pkg: state enum (ALL_RED, GREEN, YELLOW, FLASH) and lamp-encoding constants, reused by the single-light block and future pedestrian blocks.
- One sub-module: rr_next_dir, a combinational round-robin search over demand from active_dir+1, with a fallback to active_dir+1.

Test Plan:
Bench config: NUM_DIRS=4, GREEN=5, YELLOW=2, ALL_RED=1, SKIP_EMPTY=0, tick every 4 clocks.
1. Release reset, no requests -> all red until tick 1; dir0 green ticks 1-5, yellow ticks 6-7, all-red tick 8; dir1 green at tick 9; dir3 then wraps to dir0.
2. SKIP_EMPTY=1, request[2] pulsed one clock during dir0 green -> after all-red, dir2 goes green (dir1 skipped); demand[2] clears on entry.
3. flash=1 asserted during dir1 green -> green and yellow complete, then all-red. FLASH then shows all yellow toggling each tick, with red=0. Deassert -> one all-red tick, then dir2 green.
4. reset_n low mid-yellow (asynchronously, between clock edges) -> lamps all red immediately; demand cleared; restart matches scenario 1.
5. request[d] for the current green dir held high throughout its green -> not latched; with no other demand and SKIP_EMPTY=1, rotation proceeds to active_dir+1.
6. tick held 0 for 100 clocks mid-green -> phase_timer and lamps unchanged; throughout all scenarios, assert per-direction one-hot lamps and at most one non-red direction.
